// File: rtl/acc_breg_alu.sv
// acc_breg_alu
//   Accumulator + B register + add/subtract ALU sharing one bus, in the
//   style of a simple SAP-style datapath slice.
//
// Ports
//   CLK                 rising-edge clock
//   RESET               asynchronous active-low reset, clears both registers
//   in                  programmer data (load_Acc / load_Breg path)
//   bus_in              current bus value (WE_Acc / WE_Breg path)
//   WE_Acc, load_Acc    accumulator write-from-bus / load-from-programmer
//   WE_Breg, load_Breg  B register write-from-bus / load-from-programmer
//   OE_Acc, OE_Breg,
//   OE_ALU              bus output enables, priority Acc > Breg > ALU
//   SUB                 ALU mode: 0 = Acc+B, 1 = Acc-B
//   bus_out, bus_drive  value driven on the bus, and whether any OE is active
//   Acc_out, Breg_out,
//   ALU_out             continuous observation of registers and ALU result
//   carry, zero         only with ACC_BREG_ALU_FLAGS_EN defined:
//                       carry-out (subtract: 1 = no borrow), ALU result == 0
//
// Build option
//   ACC_BREG_ALU_FLAGS_EN  adds the carry/zero outputs and their logic.

module acc_breg_alu #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             WE_Acc,
    input  logic             load_Acc,
    input  logic             OE_Acc,
    input  logic             WE_Breg,
    input  logic             load_Breg,
    input  logic             OE_Breg,
    input  logic             OE_ALU,
    input  logic             SUB,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic [WIDTH-1:0] Acc_out,
    output logic [WIDTH-1:0] Breg_out,
`ifdef ACC_BREG_ALU_FLAGS_EN
    output logic             carry,
    output logic             zero,
`endif
    output logic [WIDTH-1:0] ALU_out
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH:0]   alu_wide;

    // Register next-state: bus write beats programmer load, else hold.
    always_comb begin
        acc_d = acc_q;
        if (WE_Acc)
            acc_d = bus_in;
        else if (load_Acc)
            acc_d = in;

        breg_d = breg_q;
        if (WE_Breg)
            breg_d = bus_in;
        else if (load_Breg)
            breg_d = in;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc_q  <= '0;
            breg_q <= '0;
        end else begin
            acc_q  <= acc_d;
            breg_q <= breg_d;
        end
    end

    // Subtract is Acc + ~B + 1 in WIDTH+1 bits, so the top bit is the
    // carry-out for add and the "no borrow" indication for subtract.
    always_comb begin
        alu_wide = '0;
        if (SUB)
            alu_wide = {1'b0, acc_q} + {1'b0, ~breg_q} + {{WIDTH{1'b0}}, 1'b1};
        else
            alu_wide = {1'b0, acc_q} + {1'b0, breg_q};
    end

    always_comb begin
        bus_out   = '0;
        bus_drive = 1'b0;
        if (OE_Acc) begin
            bus_out   = acc_q;
            bus_drive = 1'b1;
        end else if (OE_Breg) begin
            bus_out   = breg_q;
            bus_drive = 1'b1;
        end else if (OE_ALU) begin
            bus_out   = alu_wide[WIDTH-1:0];
            bus_drive = 1'b1;
        end
    end

    assign Acc_out  = acc_q;
    assign Breg_out = breg_q;
    assign ALU_out  = alu_wide[WIDTH-1:0];

`ifdef ACC_BREG_ALU_FLAGS_EN
    assign carry = alu_wide[WIDTH];
    assign zero  = (alu_wide[WIDTH-1:0] == '0);
`endif

endmodule

// File: tb/tb_acc_breg_alu.sv
// Scoreboard bench for acc_breg_alu. The stimulus process drives one cycle
// of controls just after each rising edge, predicts the observable outputs
// for that cycle from an integer model and queues them; the monitor pops
// and compares on every falling edge while enabled.

module tb_acc_breg_alu;

    localparam int WIDTH = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             CLK;
    logic             RESET;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_in_drv;
    logic             loop_en;
    logic             WE_Acc, load_Acc, OE_Acc;
    logic             WE_Breg, load_Breg, OE_Breg;
    logic             OE_ALU, SUB;
    logic [WIDTH-1:0] bus_out;
    logic             bus_drive;
    logic [WIDTH-1:0] Acc_out, Breg_out, ALU_out;
`ifdef ACC_BREG_ALU_FLAGS_EN
    logic             carry, zero;
`endif

    assign bus_in = loop_en ? bus_out : bus_in_drv;

    acc_breg_alu #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in        (in),
        .bus_in    (bus_in),
        .WE_Acc    (WE_Acc),
        .load_Acc  (load_Acc),
        .OE_Acc    (OE_Acc),
        .WE_Breg   (WE_Breg),
        .load_Breg (load_Breg),
        .OE_Breg   (OE_Breg),
        .OE_ALU    (OE_ALU),
        .SUB       (SUB),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .Acc_out   (Acc_out),
        .Breg_out  (Breg_out),
`ifdef ACC_BREG_ALU_FLAGS_EN
        .carry     (carry),
        .zero      (zero),
`endif
        .ALU_out   (ALU_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int acc;
        int b;
        int alu;
        int bus;
        int drv;
        int cy;
        int z;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    // Reference state held as plain integers.
    int acc_m = 0;
    int b_m   = 0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare the queued prediction against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc",       int'(Acc_out),   e.acc);
                    chk("breg",      int'(Breg_out),  e.b);
                    chk("alu",       int'(ALU_out),   e.alu);
                    chk("bus_out",   int'(bus_out),   e.bus);
                    chk("bus_drive", int'(bus_drive), e.drv);
`ifdef ACC_BREG_ALU_FLAGS_EN
                    chk("carry",     int'(carry),     e.cy);
                    chk("zero",      int'(zero),      e.z);
`endif
                end
            end
        end
    end

    // One cycle of stimulus, called just after a rising edge.
    task automatic step(input bit rst_n, input bit we_a, input bit ld_a, input bit oe_a,
                        input bit we_b, input bit ld_b, input bit oe_b, input bit oe_alu,
                        input bit sub, input int din, input int bin, input bit loop);
        exp_t e;
        int   bus_eff;
        RESET      = rst_n;
        WE_Acc     = we_a;
        load_Acc   = ld_a;
        OE_Acc     = oe_a;
        WE_Breg    = we_b;
        load_Breg  = ld_b;
        OE_Breg    = oe_b;
        OE_ALU     = oe_alu;
        SUB        = sub;
        in         = din[WIDTH-1:0];
        bus_in_drv = bin[WIDTH-1:0];
        loop_en    = loop;

        if (!rst_n) begin
            acc_m = 0;
            b_m   = 0;
        end
        e.acc = acc_m;
        e.b   = b_m;
        if (sub) begin
            e.alu = (acc_m - b_m) & MASK;
            e.cy  = (acc_m >= b_m) ? 1 : 0;
        end else begin
            e.alu = (acc_m + b_m) & MASK;
            e.cy  = (acc_m + b_m > MASK) ? 1 : 0;
        end
        e.z   = (e.alu == 0) ? 1 : 0;
        e.drv = (oe_a || oe_b || oe_alu) ? 1 : 0;
        e.bus = oe_a ? acc_m : oe_b ? b_m : oe_alu ? e.alu : 0;
        exp_q.push_back(e);

        bus_eff = loop ? e.bus : (bin & MASK);
        if (rst_n) begin
            if (we_a)      acc_m = bus_eff;
            else if (ld_a) acc_m = din & MASK;
            if (we_b)      b_m = bus_eff;
            else if (ld_b) b_m = din & MASK;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input bit sub);
        step(1, 0, 0, 0, 0, 0, 0, 0, sub, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        {WE_Acc, load_Acc, OE_Acc, WE_Breg, load_Breg, OE_Breg, OE_ALU, SUB} = '0;
        in = '0;
        bus_in_drv = '0;
        loop_en = 1'b0;
        @(posedge CLK);
        #1;
        mon_en = 1'b1;

        // Reset state, loads ignored while RESET is low.
        step(0, 1, 1, 0, 1, 1, 0, 0, 0, 8'h33, 8'h44, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Programmer loads: 5 + 3 = 8, 5 - 3 = 2.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h05, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h03, 0, 0);
        idle(0);
        idle(1);
        // WE beats load.
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 8'h11, 8'hA5, 0);
        idle(0);
        // Wraparound: FF + 01, 00 - 01.
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, 8'hFF, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h01, 0);
        idle(0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        idle(1);
        // Bus priority and idle bus.
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h10, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        idle(0);
        // OE and WE on the same register: old value on bus, new one captured.
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 8'h7E, 0);
        idle(0);
        // Loopback accumulate: Acc 2, 5, 8, 11.
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, 8'h02, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h03, 0, 0);
        repeat (4) step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h5A, 1);
        idle(0);
        // Reset overriding a same-edge load, then resume.
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h66, 8'h77, 0);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h66, 8'h77, 0);
        idle(0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            bit r, lp;
            r  = ($urandom_range(0, 39) != 0);
            lp = ($urandom_range(0, 7) == 0);
            step(r, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, MASK)),
                 int'($urandom_range(0, MASK)), lp);
        end

        // Leave both registers non-zero, then reset between clock edges.
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, 8'h9C, 0, 0);
        idle(0);
        mon_en = 1'b0;
        chk("sb_drained", exp_q.size(), 0);
        #2;
        RESET  = 1'b0;
        OE_Acc = 1'b1;
        #1;
        chk("async_acc",   int'(Acc_out),   0);
        chk("async_breg",  int'(Breg_out),  0);
        chk("async_alu",   int'(ALU_out),   0);
        chk("async_bus",   int'(bus_out),   0);
        chk("async_drive", int'(bus_drive), 1);
        OE_Acc = 1'b0;
        #1;
        chk("async_idle_bus",   int'(bus_out),   0);
        chk("async_idle_drive", int'(bus_drive), 0);
        RESET = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
